// File: rtl/dual_port_ram_param_pkg.sv
// Shared types and helpers for the parametrised simple-dual-port RAM.
// Holds the clear-engine state encoding, collision-mode constants and the address range check.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_t;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dual_port_ram_param_if.sv
// Bundles the write, read and clear-request signals of dual_port_ram_param.
// master = user side, slave = RAM side.
interface dual_port_ram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              re;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              clr_start;
  logic              busy;

  modport master (
    output we, wr_addr, wr_data, re, rd_addr, clr_start,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  we, wr_addr, wr_data, re, rd_addr, clr_start,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/dual_port_ram_param_clear_ctrl.sv
// Clear engine: sweeps every word after reset or on request, then idles.
// busy is decoded from state so it rises immediately with reset.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_start,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = clr_addr;
    busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          addr_nxt  = '0;
        end else begin
          addr_nxt = clr_addr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_start) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

endmodule

// File: rtl/dual_port_ram_param.sv
// Simple-dual-port RAM with registered read, selectable collision policy and clear engine.
// The clear engine overrides the write port while busy; user reads are suppressed then.
module dual_port_ram_param
  import ram_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              DEPTH    = 16,
  parameter int              ADDR_W   = 4,
  parameter int              RD_MODE  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic                clock,
  input logic                reset,
  dual_port_ram_param_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
    $error("dual_port_ram_param: ADDR_W too small for DEPTH");
  end
  if (RD_MODE != RD_FIRST && RD_MODE != WR_FIRST) begin : g_bad_rd_mode
    $error("dual_port_ram_param: RD_MODE must be 0 or 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_val;
  logic              rd_in_range;
  logic              collide;

  ram_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clock     (clock),
    .reset     (reset),
    .clr_start (bus.clr_start),
    .busy      (busy),
    .clr_addr  (clr_addr)
  );

  assign bus.busy = busy;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    if (busy) begin
      wr_en  = 1'b1;
      wr_idx = clr_addr[IDX_W-1:0];
      wr_val = INIT_VAL;
    end else begin
      wr_en  = bus.we && addr_ok(32'(bus.wr_addr), DEPTH);
      wr_idx = bus.wr_addr[IDX_W-1:0];
      wr_val = bus.wr_data;
    end
  end

  assign rd_in_range = addr_ok(32'(bus.rd_addr), DEPTH);
  assign collide     = bus.we && (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_val;
  end

  // The array read sees the pre-write word, which is the read-first result by construction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else if (busy) begin
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.re;
      if (bus.re) begin
        if (!rd_in_range)
          bus.rd_data <= '0;
        else if (RD_MODE == WR_FIRST && collide)
          bus.rd_data <= bus.wr_data;
        else
          bus.rd_data <= mem[bus.rd_addr[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench for dual_port_ram_param: read-first, write-first and DEPTH=12 instances
// share one stimulus stream; every expected value is hand-computed below.
module tb_dual_port_ram_param;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  dual_port_ram_param_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
  dual_port_ram_param_if #(.DATA_W(8), .ADDR_W(4)) if1 ();
  dual_port_ram_param_if #(.DATA_W(8), .ADDR_W(4)) if2 ();

  dual_port_ram_param #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .RD_MODE(0), .INIT_VAL(8'h00))
    dut0 (.clock(clock), .reset(reset), .bus(if0));
  dual_port_ram_param #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .RD_MODE(1), .INIT_VAL(8'h00))
    dut1 (.clock(clock), .reset(reset), .bus(if1));
  dual_port_ram_param #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .RD_MODE(0), .INIT_VAL(8'h00))
    dut2 (.clock(clock), .reset(reset), .bus(if2));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                     input logic r, input logic [3:0] ra, input logic c);
    if0.we = w; if0.wr_addr = wa; if0.wr_data = wd; if0.re = r; if0.rd_addr = ra; if0.clr_start = c;
    if1.we = w; if1.wr_addr = wa; if1.wr_data = wd; if1.re = r; if1.rd_addr = ra; if1.clr_start = c;
    if2.we = w; if2.wr_addr = wa; if2.wr_data = wd; if2.re = r; if2.rd_addr = ra; if2.clr_start = c;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    tick();
    tick();

    chk("rst_rd_data0", if0.rd_data, 8'h00);
    chk("rst_rd_valid0", if0.rd_valid, 1'b0);
    chk("rst_busy0", if0.busy, 1'b1);
    chk("rst_busy2", if2.busy, 1'b1);

    // Sweep after reset release: DEPTH cycles of busy
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("sweep_busy0_%0d", k), if0.busy, (k < 16) ? 1'b1 : 1'b0);
      chk($sformatf("sweep_busy2_%0d", k), if2.busy, (k < 12) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0);
      tick();
      chk($sformatf("zero_rd0_%0d", i), if0.rd_data, 8'h00);
      chk($sformatf("zero_vld0_%0d", i), if0.rd_valid, 1'b1);
      chk($sformatf("zero_rd2_%0d", i), if2.rd_data, 8'h00);
      drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      chk($sformatf("zero_vldoff0_%0d", i), if0.rd_valid, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 4'(i), 8'hA0 + 8'(i), 1'b0, 4'd0, 1'b0);
      tick();
    end

    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0);
      tick();
      e = 8'hA0 + 8'(i);
      chk($sformatf("fill_rd0_%0d", i), if0.rd_data, e);
      chk($sformatf("fill_rd1_%0d", i), if1.rd_data, e);
      chk($sformatf("fill_rd2_%0d", i), if2.rd_data, (i < 12) ? e : 8'h00);
      chk($sformatf("fill_vld0_%0d", i), if0.rd_valid, 1'b1);
      chk($sformatf("fill_vld2_%0d", i), if2.rd_valid, 1'b1);
    end
    drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    tick();
    chk("idle_vld0", if0.rd_valid, 1'b0);
    tick();
    chk("hold_rd0", if0.rd_data, 8'hAF);

    drv(1'b1, 4'd3, 8'h55, 1'b1, 4'd3, 1'b0);
    tick();
    chk("coll_rdfirst", if0.rd_data, 8'hA3);
    chk("coll_wrfirst", if1.rd_data, 8'h55);
    chk("coll_rdfirst12", if2.rd_data, 8'hA3);
    drv(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0);
    tick();
    chk("after_coll0", if0.rd_data, 8'h55);
    chk("after_coll1", if1.rd_data, 8'h55);
    chk("after_coll2", if2.rd_data, 8'h55);

    drv(1'b1, 4'd13, 8'hFF, 1'b0, 4'd0, 1'b0);
    tick();
    drv(1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 1'b0);
    tick();
    chk("oor_rd2", if2.rd_data, 8'h00);
    chk("oor_vld2", if2.rd_valid, 1'b1);
    chk("inr_rd0_13", if0.rd_data, 8'hFF);

    for (int i = 0; i < 12; i++) begin
      drv(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0);
      tick();
      e = (i == 3) ? 8'h55 : 8'hA0 + 8'(i);
      chk($sformatf("keep_rd2_%0d", i), if2.rd_data, e);
    end

    // Clear request; clr_start held for a while and user traffic applied meanwhile
    drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    tick();
    chk("clr_busy0", if0.busy, 1'b1);
    chk("clr_busy2", if2.busy, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      drv(k <= 11, 4'd5, 8'h77, k <= 11, 4'd5, k < 10);
      tick();
      chk($sformatf("clr_busy0_%0d", k), if0.busy, (k < 16) ? 1'b1 : 1'b0);
      chk($sformatf("clr_busy2_%0d", k), if2.busy, (k < 12) ? 1'b1 : 1'b0);
      chk($sformatf("clr_vld0_%0d", k), if0.rd_valid, 1'b0);
      chk($sformatf("clr_vld2_%0d", k), if2.rd_valid, 1'b0);
    end
    chk("clr_hold_rd0", if0.rd_data, 8'hAB);

    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0);
      tick();
      chk($sformatf("clr_rd0_%0d", i), if0.rd_data, 8'h00);
      chk($sformatf("clr_rd1_%0d", i), if1.rd_data, 8'h00);
      chk($sformatf("clr_rd2_%0d", i), if2.rd_data, 8'h00);
    end

    drv(1'b1, 4'd2, 8'h3C, 1'b0, 4'd0, 1'b0);
    tick();
    drv(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0);
    tick();
    chk("pre_rst_rd0", if0.rd_data, 8'h3C);
    drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    tick();
    drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    chk("mid_sweep_hold_rd0", if0.rd_data, 8'h3C);
    chk("mid_sweep_busy0", if0.busy, 1'b1);

    reset = 1'b1;
    #1;
    chk("midrst_rd0", if0.rd_data, 8'h00);
    chk("midrst_vld0", if0.rd_valid, 1'b0);
    chk("midrst_busy0", if0.busy, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      drv(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0);
      tick();
      chk($sformatf("resweep_busy0_%0d", k), if0.busy, (k < 16) ? 1'b1 : 1'b0);
      chk($sformatf("resweep_vld0_%0d", k), if0.rd_valid, 1'b0);
    end
    drv(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0);
    tick();
    chk("resweep_rd0", if0.rd_data, 8'h00);
    chk("resweep_vld0", if0.rd_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
Parametrised synchronous simple-dual-port RAM: one write port and one registered read port, both on a single clock. It replaces the bidirectional-bus single-port RAM in new designs. It adds a selectable read-during-write collision mode and a built-in clear engine that sweeps every location to a fixed value after reset or on request. It sits between datapath blocks as a scratch buffer and as the storage core for later FIFO work.

Parameters:
DATA_W, 8, data width in bits
DEPTH, 16, number of words (need not be a power of 2)
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH
RD_MODE, 0, collision policy: 0 = read-first (old data), 1 = write-first (new data)
INIT_VAL, 0, value written to every word by the clear engine

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
we  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
re  input  1  read enable
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  registered read data
rd_valid  output  1  high for one cycle when rd_data carries a new read result
clr_start  input  1  request a full clear sweep
busy  output  1  clear engine active; user ports ignored

Behaviour:
- Reset: one clock, named clock; reset is asynchronous and active-high. While reset is high: rd_data=0, rd_valid=0, busy=1, FSM=CLEAR, clr_addr=0. Memory array contents are not touched by reset itself.
- FSM states are CLEAR and IDLE.
- CLEAR: each cycle writes INIT_VAL to mem[clr_addr], then clr_addr++. After writing DEPTH-1, the next state is IDLE and clr_addr=0. The sweep takes exactly DEPTH cycles after reset deasserts. busy=1 throughout; we, re and clr_start are ignored; rd_valid=0.
- IDLE: busy=0. If clr_start=1, go to CLEAR next cycle; that same cycle's we/re are still serviced.
- Write: at the clock edge with we=1 and wr_addr<DEPTH, mem[wr_addr] <= wr_data. If wr_addr>=DEPTH, the write is dropped silently.
- Read latency is 1 cycle. re=1 sampled at edge N gives rd_data and rd_valid=1 after edge N. rd_valid returns to 0 after edge N+1 unless re is held. Back-to-back reads give one result per cycle.
- rd_data holds its last value when re=0 and during CLEAR.
- A read with rd_addr>=DEPTH returns rd_data=0 with rd_valid=1.
- Collision (we=re=1, rd_addr==wr_addr<DEPTH): RD_MODE=0 returns the pre-write content. RD_MODE=1 returns wr_data.
- Reset asserted mid-sweep or mid-read: outputs go immediately to reset values and the sweep restarts from address 0 after deassertion.
- clr_start held high during CLEAR has no effect and does not extend or restart the sweep.
- A compile-time check fails elaboration if 2**ADDR_W < DEPTH or RD_MODE is not 0 or 1.

Decomposition:
- Package ram_pkg holds the FSM state encoding (ST_CLEAR, ST_IDLE), the RD_MODE constants (RD_FIRST=0, WR_FIRST=1) and an addr_ok range-check function.
- One sub-module, ram_clear_ctrl, contains the FSM, clr_addr counter and busy flag. It drives a write-port override mux in the top.
- The array, collision logic and read register stay in the top.

Test Plan:
- Reset release, DEPTH=16: busy=1 for exactly 16 cycles then 0; reads of addresses 0..15 all return 8'h00 with rd_valid pulsing one cycle after each re.
- Write addr i with data i+8'hA0 for i=0..15, then read back 0..15 back-to-back: rd_data=A0..AF on consecutive cycles and rd_valid held high.
- Collision, write 8'h55 to addr 3 (holding 8'hA3) while reading addr 3: RD_MODE=0 gives 8'hA3; RD_MODE=1 gives 8'h55; a following read of addr 3 gives 8'h55 in both modes.
- DEPTH=12, ADDR_W=4: write 8'hFF to addr 13 then read addr 13 -> rd_data=0, rd_valid=1; addresses 0..11 are unchanged.
- After filling the memory, pulse clr_start: busy=1 for 16 cycles; we/re applied during that window are ignored (rd_valid=0); all words read back as INIT_VAL.
- Assert reset at sweep cycle 7, release: busy stays high for a full 16 cycles after release; rd_data=0 and rd_valid=0 during reset.
